uart_rx: RTL and testbench

- UART receiver, the receive-side counterpart of uart_tx, using the same 8N1 framing.
- Framing: idle-high line, one low start bit, DATA_BITS data bits LSB-first, one high stop bit.
- Synchronises the asynchronous serial input and samples each bit at mid-bit using a clock-cycle counter.
- Delivers each received byte over a valid/ready handshake, with framing-error and overrun indications.
- Sits beside uart_tx in the UART block; shares uart_tx's bit timing so uart_tx.tx_line can loop back into rx_line.

---
 rtl/uart_rx.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1-style UART receiver.
// The serial input passes through a two-flop synchroniser, a start bit is
// qualified at mid-bit, and every following bit is sampled one bit time later,
// so samples land near mid-bit. Received words are offered on a valid/ready
// handshake. Framing errors and overruns are reported as one-cycle pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_line,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_busy,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS) + 1;

    localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [DATA_BITS-1:0] rx_data_n;
    logic                 rx_valid_n;
    logic                 frame_err_n;
    logic                 overrun_n;

    logic sync_ff1, sync_ff2;
    logic rx_s;

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk) begin
        // NOTE: both flops reset to the idle level so that leaving reset
        // never looks like a falling edge on the line.
        if (rst) begin
            sync_ff1 <= 1'b1;
            sync_ff2 <= 1'b1;
        end else begin
            sync_ff1 <= rx_line;
            sync_ff2 <= sync_ff1;
        end
    end

    assign rx_s    = sync_ff2;
    assign rx_busy = (state != IDLE);

    // State register and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments here let every register update from
        // the values present before the edge, regardless of statement order.
        if (rst) begin
            state     <= WAIT_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bit_idx   <= bit_idx_n;
            shreg     <= shreg_n;
            rx_data   <= rx_data_n;
            rx_valid  <= rx_valid_n;
            frame_err <= frame_err_n;
            overrun   <= overrun_n;
        end
    end

    // Next-state, bit timing, data capture and handshake logic.
    always_comb begin
        // NOTE: every signal gets a default before the case statement so no
        // path leaves one unassigned, which would otherwise infer a latch.
        state_n     = state;
        cnt_n       = cnt;
        bit_idx_n   = bit_idx;
        shreg_n     = shreg;
        rx_data_n   = rx_data;
        rx_valid_n  = rx_valid & ~rx_ready;
        frame_err_n = 1'b0;
        overrun_n   = 1'b0;

        case (state)
            // Require one full bit time of continuous idle before listening.
            WAIT_IDLE: begin
                if (!rx_s) begin
                    cnt_n = '0;
                end else if (cnt == CNT_BIT_END) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            IDLE: begin
                if (!rx_s) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end

            // Re-check the line at mid start bit; a high level is a glitch.
            START: begin
                if (cnt == CNT_HALF_END) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        bit_idx_n = '0;
                        state_n   = DATA;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Shift in from the top so the first (LSB) bit ends in bit 0.
            DATA: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[DATA_BITS-1:1]};
                    if (bit_idx == IDX_LAST) begin
                        bit_idx_n = '0;
                        state_n   = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            // Mid stop bit: deliver, drop as overrun, or flag a framing error.
            // Returning to IDLE here leaves half a bit to catch the next start.
            STOP: begin
                if (cnt == CNT_BIT_END) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        frame_err_n = 1'b1;
                        state_n     = WAIT_IDLE;
                    end else begin
                        state_n = IDLE;
                        if (rx_valid && !rx_ready) begin
                            overrun_n = 1'b1;
                        end else begin
                            rx_data_n  = shreg;
                            rx_valid_n = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            default: begin
                state_n = WAIT_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx.
// A serialiser task drives frames with uart_tx bit timing. For every frame it
// posts an event at the clock edge where the stop bit is judged (fall edge plus
// the fixed receive latency). A per-cycle reference then derives rx_valid,
// rx_data, frame_err and overrun from those events and the handshake rules
// alone, and is compared against the DUT on every cycle after reset.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DB  = 8;
    // Edges from the ff1 capture of the falling start edge (edge 1) to rx_valid.
    localparam int LAT = 3 + CPB / 2 + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_line;
    logic          rx_ready;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_busy;
    logic          frame_err;
    logic          overrun;

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_line  (rx_line),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_busy  (rx_busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    typedef struct {
        int          at;
        logic [7:0]  data;
        bit          stop_ok;
    } ev_t;

    ev_t        ev_q[$];
    logic [7:0] got_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit model_on  = 1'b0;
    bit rand_mode = 1'b0;

    int rise_cnt = 0;
    int rise_cyc = -1;
    int fe_cnt   = 0;
    int fe_cyc   = -1;
    int ov_cnt   = 0;
    int ov_cyc   = -1;

    logic       m_valid = 1'b0;
    logic [7:0] m_data  = '0;
    logic       exp_fe  = 1'b0;
    logic       exp_ov  = 1'b0;
    logic       acc;
    ev_t        ev;
    logic       prev_v = 1'b0;
    logic [7:0] prev_d = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Advance n falling edges; in random mode rx_ready is re-drawn each cycle.
    task automatic tick_n(input int n);
        repeat (n) begin
            @(negedge clk);
            if (rand_mode) rx_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle_bits(input int n);
        rx_line = 1'b1;
        tick_n(n * CPB);
    endtask

    // Serialiser with uart_tx bit timing; call at a falling edge.
    // extra_low keeps the line low for that many extra bit times after the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok,
                              input int extra_low, output int fall);
        ev_t e;
        fall      = cyc + 1;
        e.at      = fall + LAT - 1;
        e.data    = d;
        e.stop_ok = stop_ok;
        ev_q.push_back(e);
        rx_line = 1'b0;
        tick_n(CPB);
        for (int i = 0; i < DB; i++) begin
            rx_line = d[i];
            tick_n(CPB);
        end
        rx_line = stop_ok;
        tick_n(CPB * (1 + extra_low));
        rx_line = 1'b1;
    endtask

    // Reference model and per-cycle comparison, sampled 1 time unit after each edge.
    initial forever begin
        @(posedge clk);
        cyc++;
        #1;
        if (rst) begin
            m_valid  = 1'b0;
            m_data   = '0;
            exp_fe   = 1'b0;
            exp_ov   = 1'b0;
            ev_q.delete();
            model_on = 1'b1;
        end else if (model_on) begin
            acc    = m_valid && rx_ready;
            exp_fe = 1'b0;
            exp_ov = 1'b0;
            if (prev_v && rx_ready) got_q.push_back(prev_d);
            if (ev_q.size() != 0 && ev_q[0].at == cyc) begin
                ev = ev_q.pop_front();
                if (!ev.stop_ok) begin
                    exp_fe = 1'b1;
                    if (acc) m_valid = 1'b0;
                end else if (m_valid && !acc) begin
                    exp_ov = 1'b1;
                end else begin
                    m_valid = 1'b1;
                    m_data  = ev.data;
                end
            end else if (acc) begin
                m_valid = 1'b0;
            end
        end
        if (model_on) begin
            check("outputs{valid,ferr,ovr,data}",
                  {21'd0, rx_valid, frame_err, overrun, rx_data},
                  {21'd0, m_valid, exp_fe, exp_ov, m_data});
            if (!prev_v && rx_valid) begin
                rise_cnt++;
                rise_cyc = cyc;
            end
            if (frame_err) begin
                fe_cnt++;
                fe_cyc = cyc;
            end
            if (overrun) begin
                ov_cnt++;
                ov_cyc = cyc;
            end
            prev_v = rx_valid;
            prev_d = rx_data;
        end
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        int fall;
        int fall2;
        int t0;
        int h;
        int drop;
        int r0;
        int f0;
        int o0;

        rst      = 1'b1;
        rx_line  = 1'b1;
        rx_ready = 1'b0;
        tick_n(3);
        check("reset_state", {20'd0, rx_busy, rx_valid, frame_err, overrun, rx_data}, 32'h800);
        rst = 1'b0;

        rx_ready = 1'b1;
        idle_bits(20);
        check("idle_after_reset_busy", {31'd0, rx_busy}, 32'd0);

        // Single frame 0xA5, latency from the falling start edge.
        got_q.delete();
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'hA5, 1'b1, 0, fall);
        idle_bits(2);
        check("a5_valid_beats", rise_cnt - r0, 1);
        check("a5_latency_edges", rise_cyc - fall + 1, 155);  // 3 + 8 + 9*16
        check("a5_beats_logged", got_q.size(), 1);
        if (got_q.size() > 0) check("a5_data", {24'd0, got_q[0]}, 32'hA5);
        check("a5_no_errors", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Back-to-back frames as uart_tx emits them.
        got_q.delete();
        r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
        send_frame(8'h00, 1'b1, 0, fall);
        send_frame(8'hFF, 1'b1, 0, fall);
        send_frame(8'h3C, 1'b1, 0, fall);
        idle_bits(2);
        check("b2b_beats", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_data0", {24'd0, got_q[0]}, 32'h00);
            check("b2b_data1", {24'd0, got_q[1]}, 32'hFF);
            check("b2b_data2", {24'd0, got_q[2]}, 32'h3C);
        end
        check("b2b_no_errors", (fe_cnt - f0) + (ov_cnt - o0), 0);

        // Short low glitch is rejected at mid start bit.
        r0 = rise_cnt; f0 = fe_cnt;
        t0 = cyc;
        rx_line = 1'b0;
        tick_n(4);
        rx_line = 1'b1;
        check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
        drop = -1;
        for (int i = 0; i < 24; i++) begin
            tick_n(1);
            if (!rx_busy) begin
                drop = cyc;
                break;
            end
        end
        check("glitch_busy_released", {31'd0, (drop >= 0 && drop - t0 <= CPB / 2 + 3)}, 32'd1);
        idle_bits(1);
        check("glitch_no_valid", rise_cnt - r0, 0);
        check("glitch_no_ferr", fe_cnt - f0, 0);

        // Stop bit low, line held low (break) for three bit times in total.
        got_q.delete();
        r0 = rise_cnt; f0 = fe_cnt;
        send_frame(8'h55, 1'b0, 2, fall);
        h = cyc + 1;
        check("break_busy_while_low", {31'd0, rx_busy}, 32'd1);
        check("break_ferr_pulses", fe_cnt - f0, 1);
        check("break_ferr_edge", fe_cyc - fall + 1, LAT);
        check("break_no_valid", rise_cnt - r0, 0);
        drop = -1;
        for (int i = 0; i < 40; i++) begin
            tick_n(1);
            if (!rx_busy) begin
                drop = cyc;
                break;
            end
        end
        // ff2 sees the high one edge after ff1; 16 high samples follow.
        check("break_idle_after_16_high", drop - h, 17);
        idle_bits(2);
        send_frame(8'h81, 1'b1, 0, fall);
        idle_bits(2);
        check("after_break_beats", got_q.size(), 1);
        if (got_q.size() > 0) check("after_break_data", {24'd0, got_q[0]}, 32'h81);

        // Overrun: consumer stalled for two frames.
        got_q.delete();
        o0 = ov_cnt;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0, fall);
        send_frame(8'h22, 1'b1, 0, fall2);
        idle_bits(1);
        check("ovr_held_byte", {23'd0, rx_valid, rx_data}, 32'h111);
        check("ovr_pulses", ov_cnt - o0, 1);
        check("ovr_edge", ov_cyc - fall2 + 1, LAT);
        rx_ready = 1'b1;
        tick_n(1);
        check("ovr_valid_cleared", {31'd0, rx_valid}, 32'd0);
        check("ovr_accepted", got_q.size(), 1);

        // Reset pulse in the middle of data bit 4.
        got_q.delete();
        r0 = rise_cnt;
        fork
            send_frame(8'h96, 1'b1, 0, fall);
            begin
                tick_n(5 * CPB + CPB / 2);
                rst = 1'b1;
                tick_n(1);
                rst = 1'b0;
                check("rst_mid_frame", {20'd0, rx_busy, rx_valid, frame_err, overrun, rx_data}, 32'h800);
            end
        join
        idle_bits(2);
        check("rst_aborted_no_valid", rise_cnt - r0, 0);
        send_frame(8'h69, 1'b1, 0, fall);
        idle_bits(2);
        check("rst_next_beats", got_q.size(), 1);
        if (got_q.size() > 0) check("rst_next_data", {24'd0, got_q[0]}, 32'h69);

        // Randomized traffic: data, gaps, bad stop bits and consumer stalls.
        rand_mode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bit ok;
            int gap;
            ok  = ($urandom_range(0, 7) != 0);
            gap = ok ? int'($urandom_range(0, 2)) : 2;
            send_frame(8'($urandom), ok, 0, fall);
            idle_bits(gap);
        end
        rand_mode = 1'b0;
        rx_ready  = 1'b1;
        idle_bits(3);
        check("events_drained", ev_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
